// File: rtl/aes_pkg.sv
// Shared AES-system definitions: block width, UART transmitter state encoding
// and the default baud divisor (50 MHz / 115200).
package aes_pkg;

    localparam int AES_BLOCK_W          = 128;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: emits a one-cycle tick every CLKS_PER_BIT cycles while
// i_clear is low. Holding i_clear high parks the counter at zero, so the first
// tick after release arrives exactly CLKS_PER_BIT cycles later. Shared with the
// planned UART receiver.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign o_tick = w_wrap && !i_clear;

    // Free-running divider that wraps at CLKS_PER_BIT-1 and is held by clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear || w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/aes_result_uart_tx.sv
// AES result UART transmitter. Captures the selected 128-bit result on the
// rising edge of its ready flag and sends it MSB byte first, LSB bit first,
// as back-to-back UART frames. Frame is 8N1 by default; define
// AES_UART_PARITY_EN for 8E1 (even parity bit after bit 7).
module aes_result_uart_tx
    import aes_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = AES_BLOCK_W / 8,
    localparam int DATA_W      = 8 * NUM_BYTES,
    localparam int IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Valid,
    output logic              o_Tx,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [IDX_W-1:0]  o_ByteIdx
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    uart_state_t       r_state;
    logic [DATA_W-1:0] r_block;     // remaining bytes, next byte at the top
    logic [7:0]        r_shift;     // byte on the wire, LSB is current bit
    logic [2:0]        r_bit_cnt;
    logic [IDX_W-1:0]  r_byte_idx;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;     // Valid history for edge detect
    logic              r_armed;     // Valid has been seen low since reset
`ifdef AES_UART_PARITY_EN
    logic              r_par;       // running XOR of bits already sent
`endif

    logic w_start;
    logic w_tick;
    logic w_baud_clr;

    // A start needs a genuine low-to-high transition seen after reset
    assign w_start    = i_Valid && !r_valid && r_armed;
    // Counter is parked in IDLE so START lasts exactly one bit time
    assign w_baud_clr = (r_state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk   (i_Clk),
        .i_rst   (i_Rst),
        .i_clear (w_baud_clr),
        .o_tick  (w_tick)
    );

    assign o_Tx      = r_tx;
    assign o_Busy    = r_busy;
    assign o_Done    = r_done;
    assign o_ByteIdx = r_byte_idx;

    // Transmit FSM with registered line, status and byte index
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= ST_IDLE;
            r_block    <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_armed    <= 1'b0;
`ifdef AES_UART_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_valid <= i_Valid;
            if (!i_Valid)
                r_armed <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_done <= 1'b0;
                    if (r_busy) begin
                        // Cycle after capture: drop the line for byte 0
                        r_state   <= ST_START;
                        r_tx      <= 1'b0;
                        r_shift   <= r_block[DATA_W-1 -: 8];
                        r_block   <= r_block << 8;
                        r_bit_cnt <= '0;
                    end else if (w_start) begin
                        r_block <= i_Data;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
`ifdef AES_UART_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
`ifdef AES_UART_PARITY_EN
                            r_state   <= ST_PARITY;
                            r_tx      <= r_par ^ r_shift[0];
`else
                            r_state   <= ST_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
`ifdef AES_UART_PARITY_EN
                            r_par     <= r_par ^ r_shift[0];
`endif
                        end
                    end
                end

`ifdef AES_UART_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_tick) begin
                        if (r_byte_idx < LAST_IDX) begin
                            // Next byte starts immediately, no idle gap
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_shift    <= r_block[DATA_W-1 -: 8];
                            r_block    <= r_block << 8;
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end else begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_byte_idx <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    // Any edge landing here is consumed by r_valid, not queued
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// Directed bench for aes_result_uart_tx at CLKS_PER_BIT=4, NUM_BYTES=16.
// Define AES_UART_PARITY_EN to exercise the 8E1 build.
module tb_aes_result_uart_tx;
    localparam int CPB = 4;
    localparam int NB  = 16;
`ifdef AES_UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int BLK_LEN = NB * FRAME * CPB;   // 640, or 704 with parity

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [127:0] data = '0;
    logic         tx, busy, done;
    logic [3:0]   idx;

    aes_result_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Data    (data),
        .i_Valid   (valid),
        .o_Tx      (tx),
        .o_Busy    (busy),
        .o_Done    (done),
        .o_ByteIdx (idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cycles = 0, done_count = 0;
    int fall_cyc = 0, done_cyc = 0, busy_rise_cyc = 0;
    logic tx_q = 1'b1, busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: busy length, done pulses, first start-bit edge
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin done_count++; done_cyc = cyc; end
        if (tx === 1'b0 && tx_q === 1'b1 && idx === 4'd0) fall_cyc = cyc;
        if (busy === 1'b1 && busy_q !== 1'b1) busy_rise_cyc = cyc;
        tx_q   = tx;
        busy_q = busy;
    end

    // Decode one UART frame by sampling mid-bit
    task automatic recv_byte(output logic [7:0] b, output logic p,
                             output logic [3:0] ix, output bit ok);
        int n = 0;
        ok = 0; b = '0; p = 1'b0; ix = '0;
        while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (tx !== 1'b0) return;
        repeat (CPB/2) @(negedge clk);
        ix = idx;
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
`ifdef AES_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) return;
        ok = 1;
    endtask

    // Decode a whole block; got holds bytes in wire order, first at the top
    task automatic recv_block(output logic [127:0] got, output bit ok,
                              output bit idx_ok, output logic [15:0] pbits);
        logic [7:0] b;
        logic       p;
        logic [3:0] ix;
        bit         bok;
        got = '0; ok = 1; idx_ok = 1; pbits = '0;
        for (int k = 0; k < NB; k++) begin
            recv_byte(b, p, ix, bok);
            got[127-8*k -: 8] = b;
            pbits[k] = p;
            if (!bok) begin ok = 0; return; end
            if (ix !== 4'(k)) idx_ok = 0;
        end
    endtask

    task automatic wait_done(output bit seen);
        int n = 0;
        seen = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        seen = (done === 1'b1);
    endtask

    task automatic wait_idx(input logic [3:0] want, output bit seen);
        int n = 0;
        while (idx !== want && n < 3000) begin @(negedge clk); n++; end
        seen = (idx === want);
    endtask

    task automatic rearm();
        valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b idx=%0d, want 1 0 0 0", tx, busy, done, idx);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_100: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_single_block();
        logic [127:0] exp = 128'h00112233445566778899AABBCCDDEEFF;
        logic [127:0] got;
        logic [15:0]  pb;
        bit ok, iok, seen;
        int b0, d0;
        b0 = busy_cycles; d0 = done_count;
        data = exp;
        valid = 1'b1;
        recv_block(got, ok, iok, pb);
        wait_done(seen);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL single_bytes: got %h framed=%0d, want %h", got, ok, exp);
        end
        checks++;
        if (!iok) begin
            failures++;
            $display("FAIL single_byteidx: ByteIdx did not track 0..15");
        end
        checks++;
        if (!seen || done_count - d0 != 1) begin
            failures++;
            $display("FAIL single_done: pulses=%0d, want 1", done_count - d0);
        end
        checks++;
        if (busy_cycles - b0 != BLK_LEN + 1) begin
            failures++;
            $display("FAIL single_busy_len: %0d, want %0d", busy_cycles - b0, BLK_LEN + 1);
        end
        checks++;
        if (done_cyc - fall_cyc != BLK_LEN) begin
            failures++;
            $display("FAIL single_blk_len: %0d, want %0d", done_cyc - fall_cyc, BLK_LEN);
        end
        checks++;
        if (fall_cyc - busy_rise_cyc != 1) begin
            failures++;
            $display("FAIL single_tx_latency: %0d, want 1", fall_cyc - busy_rise_cyc);
        end
        b0 = busy_cycles; d0 = done_count;
        repeat (200) @(negedge clk);
        checks++;
        if (busy_cycles != b0 || done_count != d0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL no_resend: busy_cyc=%0d done=%0d tx=%b, want 0 0 1",
                     busy_cycles - b0, done_count - d0, tx);
        end
    endtask

    task automatic test_retrigger();
        logic [127:0] d1 = 128'h0123456789ABCDEFFEDCBA9876543210;
        logic [127:0] d2 = 128'hC3A5_5A3C_0180_7F01_FFEE_1234_8001_6996;
        logic [127:0] got;
        logic [15:0]  pb;
        bit ok, iok, seen, seen5;
        int b0, d0;
        rearm();
        b0 = busy_cycles; d0 = done_count;
        data = d1;
        valid = 1'b1;
        fork
            recv_block(got, ok, iok, pb);
            begin
                wait_idx(4'd5, seen5);
                repeat (3) @(negedge clk);
                valid = 1'b0;
                repeat (2) @(negedge clk);
                valid = 1'b1;
            end
        join
        wait_done(seen);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || got !== d1 || !seen5) begin
            failures++;
            $display("FAIL retrig_bytes: got %h framed=%0d, want %h", got, ok, d1);
        end
        checks++;
        if (done_count - d0 != 1 || busy_cycles - b0 != BLK_LEN + 1) begin
            failures++;
            $display("FAIL retrig_single_block: done=%0d busy=%0d, want 1 %0d",
                     done_count - d0, busy_cycles - b0, BLK_LEN + 1);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL retrig_not_queued: busy=%b, want 0", busy);
        end
        rearm();
        data = d2;
        valid = 1'b1;
        recv_block(got, ok, iok, pb);
        wait_done(seen);
        checks++;
        if (!ok || got !== d2 || !seen) begin
            failures++;
            $display("FAIL second_block: got %h framed=%0d, want %h", got, ok, d2);
        end
    endtask

    task automatic test_data_change();
        logic [127:0] d3 = 128'h5A5A_0F0F_F0F0_A5A5_1122_3344_0000_8181;
        logic [127:0] got;
        logic [15:0]  pb;
        bit ok, iok, seen, seen7;
        rearm();
        data = d3;
        valid = 1'b1;
        fork
            recv_block(got, ok, iok, pb);
            begin
                wait_idx(4'd7, seen7);
                data = '1;
            end
        join
        wait_done(seen);
        checks++;
        if (!ok || got !== d3 || !seen7) begin
            failures++;
            $display("FAIL data_change: got %h framed=%0d, want %h", got, ok, d3);
        end
    endtask

    task automatic test_reset_midframe();
        logic [127:0] d4 = 128'h0F0E0D0C0B0A09080706050403020100;
        logic [127:0] got;
        logic [15:0]  pb;
        bit ok, iok, seen, seen3;
        int d0, bad;
        rearm();
        data = d4;
        valid = 1'b1;
        wait_idx(4'd3, seen3);
        repeat (8) @(negedge clk);
        checks++;
        if (!seen3 || tx !== 1'b0) begin
            failures++;
            $display("FAIL midframe_setup: reached=%0d tx=%b, want 1 0", seen3, tx);
        end
        d0 = done_count;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || idx !== 4'd0) begin
            failures++;
            $display("FAIL midframe_async: tx=%b busy=%b idx=%0d, want 1 0 0", tx, busy, idx);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || done_count != d0) begin
            failures++;
            $display("FAIL midframe_quiet: bad=%0d done=%0d, want 0 0", bad, done_count - d0);
        end
        rearm();
        valid = 1'b1;
        recv_block(got, ok, iok, pb);
        wait_done(seen);
        checks++;
        if (!ok || got !== d4 || !seen) begin
            failures++;
            $display("FAIL after_reset_block: got %h framed=%0d, want %h", got, ok, d4);
        end
    endtask

`ifdef AES_UART_PARITY_EN
    task automatic test_parity();
        logic [127:0] dp = 128'h0703_0000_0000_0000_0000_0000_0000_00FF;
        logic [127:0] got;
        logic [15:0]  pb;
        bit ok, iok, seen;
        rearm();
        data = dp;
        valid = 1'b1;
        recv_block(got, ok, iok, pb);
        wait_done(seen);
        checks++;
        if (!ok || got !== dp) begin
            failures++;
            $display("FAIL parity_bytes: got %h, want %h", got, dp);
        end
        checks++;
        if (pb[0] !== 1'b1 || pb[1] !== 1'b0 || pb[2] !== 1'b0 || pb[15] !== 1'b0) begin
            failures++;
            $display("FAIL parity_bits: got %b, want 07->1 03->0 00->0 FF->0", pb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_retrigger();
        test_data_change();
        test_reset_midframe();
`ifdef AES_UART_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
